spi_master_driver: RTL

//  SPI master controller, CPOL=0 CPHA=0, LSB-first, DATA_WIDTH-bit frames, single slave.
//  It pairs with the team's mode-0 slave: it drives SCLK, CS_n and MOSI, and captures MISO.
//  The system side issues one frame per start pulse and reads the received word after done.
//  It sits between the bus-side register block and the SPI pins.

---
 rtl/spi_master_driver_pkg.sv | 23 ++
 rtl/spi_master_driver_tick_gen.sv | 38 +++
 rtl/spi_master_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spi_master_driver_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_driver_pkg
//   Shared definitions for the mode-0 (CPOL=0, CPHA=0), LSB-first SPI master:
//   default frame width and divider, the SCLK idle level and the FSM state
//   encoding used by the controller.
// ---------------------------------------------------------------------------
package spi_master_driver_pkg;

    localparam int SPI_DEFAULT_WIDTH = 8;
    localparam int SPI_DEFAULT_DIV   = 2;

    // CPOL=0: SCLK rests low between frames and after every falling edge.
    localparam logic SPI_SCLK_IDLE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,   // waiting for start_i, CS high
        ST_SETUP,  // CS low, first bit on MOSI, SCLK still low
        ST_HIGH,   // SCLK high half-period (MISO captured on entry)
        ST_LOW,    // SCLK low half-period (shift happened on entry)
        ST_HOLD    // CS hold after the last falling edge
    } state_t;

endpackage

// File: rtl/spi_master_driver_tick_gen.sv
// ---------------------------------------------------------------------------
// spi_master_driver_tick_gen
//   Divider that counts CLK_DIV clk_i cycles while enabled and raises tick_o
//   in the last cycle of every CLK_DIV-cycle window. The count is held at 0
//   while disabled, so each enable rise starts a fresh full window.
// Ports
//   clk_i   in   system clock
//   rst_i   in   synchronous reset, active-high
//   en_i    in   count enable
//   tick_o  out  1-cycle tick, once per CLK_DIV enabled cycles
// ---------------------------------------------------------------------------
module spi_master_driver_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int             CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick_o = en_i && (cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt <= '0;
        end else if (tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_driver.sv
// ---------------------------------------------------------------------------
// spi_master_driver
//   SPI master, CPOL=0 / CPHA=0, LSB-first, DATA_WIDTH-bit frames, one slave.
//   One frame per accepted start pulse; the received word is presented on
//   data_out_bo together with a 1-cycle done_o pulse. All outputs are
//   registered. DATA_WIDTH must be at least 2.
// Ports
//   clk_i        in   system clock
//   rst_i        in   synchronous reset, active-high
//   start_i      in   begin a frame (only looked at while ready_o=1)
//   data_in_bi   in   word to transmit, latched in the start cycle
//   ready_o      out  idle, start_i accepted
//   done_o       out  1-cycle pulse at end of frame
//   data_out_bo  out  last received word, held until the next done_o
//   spi_sclk_o   out  SPI clock, idles low
//   spi_mosi_o   out  master out, 0 while CS is high
//   spi_miso_i   in   master in
//   spi_cs_o     out  chip select, active-low
// ---------------------------------------------------------------------------
module spi_master_driver
    import spi_master_driver_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DEFAULT_WIDTH,
    parameter int CLK_DIV    = SPI_DEFAULT_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_in_bi,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] data_out_bo,
    output logic                  spi_sclk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    output logic                  spi_cs_o
);

    localparam int            BW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  bit_buf;
    logic [BW-1:0]         bit_cnt;
    logic                  tick;

    // One-cycle action strobes decoded from the FSM; at most one is high.
    logic do_load;
    logic do_rise;
    logic do_fall;
    logic do_finish;

    // The divider runs for the whole frame, SETUP through HOLD.
    spi_master_driver_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state != ST_IDLE),
        .tick_o (tick)
    );

    // The bit sampled on the last rising edge enters at the MSB while the
    // word moves toward bit 0, so after DATA_WIDTH falls the first received
    // bit sits at bit 0 (LSB-first).
    assign shift_next = {bit_buf, shift_reg[DATA_WIDTH-1:1]};

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        do_finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_SETUP;
                    do_load    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_next = ST_HIGH;
                    do_rise    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    state_next = ST_LOW;
                    do_fall    = 1'b1;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    // bit_cnt already counts the fall that led into LOW.
                    if (bit_cnt == LAST_BIT) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_HIGH;
                        do_rise    = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_next = ST_IDLE;
                    do_finish  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_reg   <= '0;
            bit_buf     <= 1'b0;
            bit_cnt     <= '0;
            ready_o     <= 1'b1;
            done_o      <= 1'b0;
            data_out_bo <= '0;
            spi_sclk_o  <= SPI_SCLK_IDLE;
            spi_mosi_o  <= 1'b0;
            spi_cs_o    <= 1'b1;
        end else begin
            done_o <= 1'b0;

            if (do_load) begin
                shift_reg  <= data_in_bi;
                bit_cnt    <= '0;
                ready_o    <= 1'b0;
                spi_cs_o   <= 1'b0;
                spi_sclk_o <= SPI_SCLK_IDLE;
                spi_mosi_o <= data_in_bi[0];
            end

            if (do_rise) begin
                spi_sclk_o <= ~SPI_SCLK_IDLE;
                bit_buf    <= spi_miso_i;
            end

            if (do_fall) begin
                spi_sclk_o <= SPI_SCLK_IDLE;
                shift_reg  <= shift_next;
                spi_mosi_o <= shift_next[0];
                bit_cnt    <= bit_cnt + 1'b1;
            end

            if (do_finish) begin
                spi_cs_o    <= 1'b1;
                spi_mosi_o  <= 1'b0;
                ready_o     <= 1'b1;
                done_o      <= 1'b1;
                data_out_bo <= shift_reg;
            end
        end
    end

endmodule
